// File: rtl/piano_pkg.sv
// Shared piano definitions: sequencer mode encodings and note frequency codes.
// REST_FREQ is the code the keyboard emits with no key down; the sequencer
// never compares freq words itself, it trusts the keyboard's note_valid flag.
package piano_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_REC  = 2'd1,
        MODE_PLAY = 2'd2
    } mode_t;

    localparam logic [31:0] REST_FREQ   = 32'd20000;
    localparam logic [31:0] SILENT_FREQ = 32'd100000000;

endpackage

// File: rtl/beat_tick_gen.sv
// Free-running beat divider: one-cycle pulse every CLK_FREQ/BEAT_HZ clocks.
// The pulse is high while the counter sits on its last value, so the wrap
// edge is the edge that consumes the tick.
module beat_tick_gen #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BEAT_HZ  = 8
) (
    input  logic clk,
    input  logic reset,
    output logic beat_tick
);

    localparam int DIV = CLK_FREQ / BEAT_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // count 0..DIV-1 and wrap, independent of sequencer mode
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign beat_tick = (cnt == CNT_MAX);

endmodule

// File: rtl/recorder_seq_ctrl.sv
// Record/playback sequencer for the piano note RAM (one freq word per beat).
// Button pulses drive an IDLE/REC/PLAY FSM; on each beat it writes (REC) or
// steps the read address (PLAY). last_addr tracks the last non-rest beat so
// trailing rests are trimmed from the song.
// Build option: define REC_LOOP_EN to loop playback continuously; otherwise
// playback returns to IDLE at the end of the song.
module recorder_seq_ctrl
    import piano_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BEAT_HZ   = 8,
    parameter int MEM_DEPTH = 1000,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_rec,
    input  logic              btn_play,
    input  logic              btn_stop,
    input  logic              note_valid,
    output logic              beat_tick,
    output logic              mem_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] last_addr,
    output logic              mute,
    output logic [1:0]        mode,
    output logic              full
);

    localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(MEM_DEPTH - 1);

    mode_t st;
    logic  has_song;

    beat_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BEAT_HZ  (BEAT_HZ)
    ) u_tick (
        .clk       (clk),
        .reset     (reset),
        .beat_tick (beat_tick)
    );

    // the RAM commits the word on the tick edge at the current wr_addr
    assign mem_we = beat_tick && (st == MODE_REC);
    assign mode   = st;

    // mode FSM plus address/length bookkeeping; button handling is written
    // after the beat handling so a command overrides the beat on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= MODE_IDLE;
            wr_addr   <= '0;
            rd_addr   <= '0;
            last_addr <= '0;
            has_song  <= 1'b0;
            mute      <= 1'b1;
            full      <= 1'b0;
        end else begin
            case (st)
                MODE_IDLE: begin
                    if (!btn_stop) begin
                        if (btn_rec) begin
                            st        <= MODE_REC;
                            wr_addr   <= '0;
                            last_addr <= '0;
                            has_song  <= 1'b0;
                            full      <= 1'b0;
                        end else if (btn_play && has_song) begin
                            st      <= MODE_PLAY;
                            rd_addr <= '0;
                            mute    <= 1'b0;
                        end
                    end
                end
                MODE_REC: begin
                    if (beat_tick) begin
                        if (note_valid) begin
                            last_addr <= wr_addr;
                            has_song  <= 1'b1;
                        end
                        if (wr_addr == ADDR_END) begin
                            st   <= MODE_IDLE;
                            full <= 1'b1;
                        end else begin
                            wr_addr <= wr_addr + 1'b1;
                        end
                    end
                    if (btn_stop) begin
                        st <= MODE_IDLE;
                    end else if (btn_rec) begin
                        st        <= MODE_REC;
                        wr_addr   <= '0;
                        last_addr <= '0;
                        has_song  <= 1'b0;
                        full      <= 1'b0;
                    end else if (btn_play) begin
                        st <= MODE_IDLE;
                    end
                end
                MODE_PLAY: begin
                    if (beat_tick) begin
                        if (rd_addr == last_addr) begin
                            rd_addr <= '0;
`ifdef REC_LOOP_EN
                            st      <= MODE_PLAY;
`else
                            st      <= MODE_IDLE;
                            mute    <= 1'b1;
`endif
                        end else begin
                            rd_addr <= rd_addr + 1'b1;
                        end
                    end
                    if (btn_stop) begin
                        st      <= MODE_IDLE;
                        rd_addr <= '0;
                        mute    <= 1'b1;
                    end else if (btn_rec) begin
                        st        <= MODE_REC;
                        rd_addr   <= '0;
                        mute      <= 1'b1;
                        wr_addr   <= '0;
                        last_addr <= '0;
                        has_song  <= 1'b0;
                        full      <= 1'b0;
                    end else if (btn_play) begin
                        st      <= MODE_PLAY;
                        rd_addr <= '0;
                        mute    <= 1'b0;
                    end
                end
                default: begin
                    st   <= MODE_IDLE;
                    mute <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_recorder_seq_ctrl.sv
// Directed bench for recorder_seq_ctrl at CLK_FREQ=80, BEAT_HZ=8 (tick every
// 10 clocks). A second instance with MEM_DEPTH=4 shares all inputs and is
// used for the memory-full case.
module tb_recorder_seq_ctrl;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          btn_rec = 1'b0, btn_play = 1'b0, btn_stop = 1'b0;
    logic          note_valid = 1'b0;

    logic          d1_tick, d1_we, d1_mute, d1_full;
    logic [AW-1:0] d1_wr, d1_rd, d1_last;
    logic [1:0]    d1_mode;

    logic          d2_tick, d2_we, d2_mute, d2_full;
    logic [AW-1:0] d2_wr, d2_rd, d2_last;
    logic [1:0]    d2_mode;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    recorder_seq_ctrl #(.CLK_FREQ(80), .BEAT_HZ(8), .MEM_DEPTH(1000), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .btn_rec(btn_rec), .btn_play(btn_play),
        .btn_stop(btn_stop), .note_valid(note_valid), .beat_tick(d1_tick),
        .mem_we(d1_we), .wr_addr(d1_wr), .rd_addr(d1_rd), .last_addr(d1_last),
        .mute(d1_mute), .mode(d1_mode), .full(d1_full)
    );

    recorder_seq_ctrl #(.CLK_FREQ(80), .BEAT_HZ(8), .MEM_DEPTH(4), .ADDR_W(AW)) dut4 (
        .clk(clk), .reset(reset), .btn_rec(btn_rec), .btn_play(btn_play),
        .btn_stop(btn_stop), .note_valid(note_valid), .beat_tick(d2_tick),
        .mem_we(d2_we), .wr_addr(d2_wr), .rd_addr(d2_rd), .last_addr(d2_last),
        .mute(d2_mute), .mode(d2_mode), .full(d2_full)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d", tag, act, exp);
        end
    endtask

    // one-cycle button pulse, driven just after a rising edge
    task automatic press(input logic r, input logic p, input logic s);
        @(posedge clk); #1;
        btn_rec = r; btn_play = p; btn_stop = s;
        @(posedge clk); #1;
        btn_rec = 1'b0; btn_play = 1'b0; btn_stop = 1'b0;
        @(negedge clk);
    endtask

    // stop on the falling edge where beat_tick is high (bounded)
    task automatic wait_tick();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (d1_tick) seen = 1'b1;
        end
        if (!seen) chk("tick_timeout", 0, 1);
    endtask

    initial begin
        int n;
        bit seen;

        // 1. reset mid-count, then first tick position
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_tick", d1_tick, 0);
        chk("rst_mode", d1_mode, 0);
        chk("rst_mute", d1_mute, 1);
        chk("rst_full", d1_full, 0);
        chk("rst_we",   d1_we, 0);
        chk("rst_wr",   d1_wr, 0);
        chk("rst_rd",   d1_rd, 0);
        chk("rst_last", d1_last, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        // n counts clock periods after release; the tick should be high in the 10th
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            n++;
            if (d1_tick) seen = 1'b1;
        end
        chk("first_tick", n, 10);

        // 4. play with no song is ignored
        press(1'b0, 1'b1, 1'b0);
        chk("nosong_mode", d1_mode, 0);
        chk("nosong_rd",   d1_rd, 0);
        chk("nosong_mute", d1_mute, 1);

        // 2. record 5 notes then 3 rests; dut4 fills after 4 beats
        press(1'b1, 1'b0, 1'b0);
        chk("rec_mode", d1_mode, 1);
        chk("rec_mute", d1_mute, 1);
        for (int b = 0; b < 8; b++) begin
            note_valid = (b < 5);
            wait_tick();
            chk($sformatf("rec_we%0d", b), d1_we, 1);
            chk($sformatf("rec_wr%0d", b), d1_wr, b);
            chk($sformatf("d4_we%0d", b), d2_we, (b < 4) ? 1 : 0);
            if (b < 4) chk($sformatf("d4_wr%0d", b), d2_wr, b);
            @(negedge clk);
            chk($sformatf("rec_we_off%0d", b), d1_we, 0);
            chk($sformatf("rec_mode%0d", b), d1_mode, 1);
            if (b == 3) begin
                // 5. memory-full stop on the smaller instance
                chk("d4_full_mode", d2_mode, 0);
                chk("d4_full",      d2_full, 1);
                chk("d4_full_wr",   d2_wr, 3);
            end
        end
        press(1'b0, 1'b0, 1'b1);
        note_valid = 1'b0;
        chk("stop_mode", d1_mode, 0);
        chk("stop_wr",   d1_wr, 8);
        chk("stop_last", d1_last, 4);
        chk("stop_mute", d1_mute, 1);
        chk("stop_full", d1_full, 0);

        // 3. playback of addresses 0..4
        press(1'b0, 1'b1, 1'b0);
        chk("play_mode", d1_mode, 2);
        chk("play_mute", d1_mute, 0);
        chk("play_rd",   d1_rd, 0);
        for (int b = 0; b < 5; b++) begin
            wait_tick();
            chk($sformatf("play_rd%0d", b), d1_rd, b);
            chk($sformatf("play_mode%0d", b), d1_mode, 2);
        end
        @(negedge clk);
        chk("end_rd",   d1_rd, 0);
        chk("end_wr",   d1_wr, 8);
`ifdef REC_LOOP_EN
        chk("end_mode", d1_mode, 2);
        chk("end_mute", d1_mute, 0);
        wait_tick();
        chk("loop_rd0", d1_rd, 0);
        @(negedge clk);
        chk("loop_rd1", d1_rd, 1);
`else
        chk("end_mode", d1_mode, 0);
        chk("end_mute", d1_mute, 1);
`endif

        // 6. stop wins over rec and play during PLAY
        press(1'b0, 1'b1, 1'b0);
        chk("p6_mode", d1_mode, 2);
        press(1'b1, 1'b1, 1'b1);
        chk("all3_mode", d1_mode, 0);
        chk("all3_rd",   d1_rd, 0);
        chk("all3_mute", d1_mute, 1);
        chk("all3_last", d1_last, 4);

        // 5. next rec clears the sticky full flag
        press(1'b1, 1'b0, 1'b0);
        chk("d4_reclr_full", d2_full, 0);
        chk("d4_reclr_mode", d2_mode, 1);
        chk("rerec_mode", d1_mode, 1);
        chk("rerec_last", d1_last, 0);
        chk("rerec_wr",   d1_wr, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
